// File: rtl/ram_arb_pkg.sv
// Shared widths and grant encoding for the system RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_HOST
  } grant_e;

endpackage

// File: rtl/ram_arb_starve.sv
// Host starvation guard: counts host wait cycles and raises a registered
// force flag that claims the next RAM slot for the host.
module ram_arb_starve
  import ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic resetq,
  input  logic host_req,
  input  logic host_gnt,
  output logic force_host
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      wait_cnt   <= '0;
      force_host <= 1'b0;
    end else if (host_gnt || !host_req) begin
      wait_cnt   <= '0;
      force_host <= 1'b0;
    end else if (wait_cnt == LIMIT) begin
      force_host <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the system RAM between the cdp1802 core (default priority) and a
// host/loader port. Define RAM_ARBITER_STARVE_EN to bound host latency.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              resetq,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_wait,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_a,
  input  logic [DATA_W-1:0] host_d,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_q,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  logic   cpu_act;
  logic   force_host;
  logic   rd1;
  grant_e gnt;

  assign cpu_act = cpu_rd | cpu_wr;

`ifdef RAM_ARBITER_STARVE_EN
  ram_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock      (clock),
    .resetq     (resetq),
    .host_req   (host_req),
    .host_gnt   (host_gnt),
    .force_host (force_host)
  );
`else
  logic unused_limit;
  assign unused_limit = (STARVE_LIMIT == 0);
  assign force_host   = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = GNT_NONE;
    if (host_req && (!cpu_act || force_host)) gnt = GNT_HOST;
    else if (cpu_act)                         gnt = GNT_CPU;
  end

  always_comb begin
    ram_rd = 1'b0;
    ram_wr = 1'b0;
    ram_a  = cpu_a;
    ram_d  = cpu_d;
    unique case (gnt)
      GNT_HOST: begin
        ram_a  = host_a;
        ram_d  = host_d;
        ram_wr = host_we;
        ram_rd = !host_we;
      end
      // A simultaneous read+write strobe from the CPU is treated as a write.
      GNT_CPU: begin
        ram_wr = cpu_wr;
        ram_rd = cpu_rd & !cpu_wr;
      end
      default: ;
    endcase
  end

  assign host_gnt = (gnt == GNT_HOST);
  assign cpu_wait = cpu_act & host_gnt;
  assign cpu_q    = ram_q;

  // rd1 marks the cycle in which ram_q carries the host's read data.
  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      rd1         <= 1'b0;
      host_rvalid <= 1'b0;
      host_q      <= '0;
    end else begin
      rd1         <= host_gnt & !host_we;
      host_rvalid <= rd1;
      if (rd1) host_q <= ram_q;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a synchronous RAM model; honours
// RAM_ARBITER_STARVE_EN to select the matching starvation scenario.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        resetq;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d, cpu_q;
  logic        cpu_wait;
  logic        host_req, host_we;
  logic [15:0] host_a;
  logic [7:0]  host_d, host_q;
  logic        host_gnt, host_rvalid;
  logic        ram_rd, ram_wr;
  logic [15:0] ram_a;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;

  logic [7:0]  mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wr) mem[ram_a] <= ram_d;
    if (ram_rd) ram_q <= mem[ram_a];
  end

  ram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clock       (clock),
    .resetq      (resetq),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_a       (cpu_a),
    .cpu_d       (cpu_d),
    .cpu_q       (cpu_q),
    .cpu_wait    (cpu_wait),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_a      (host_a),
    .host_d      (host_d),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_q      (host_q),
    .ram_rd      (ram_rd),
    .ram_wr      (ram_wr),
    .ram_a       (ram_a),
    .ram_d       (ram_d),
    .ram_q       (ram_q)
  );

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_a = 16'h0000; host_d = 8'h00;
  endtask

  // Advance to 1 ns after the next rising edge, where new inputs are applied.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetq = 1'b0;
    idle_inputs();
    #2;
    n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", host_rvalid); end
    n_cmp++; if (host_q !== 8'h00) begin n_bad++; $display("FAIL rst_host_q: got %h want 00", host_q); end
    n_cmp++; if ({host_gnt, cpu_wait, ram_rd, ram_wr} !== 4'b0000) begin n_bad++; $display("FAIL rst_idle: got %b want 0000", {host_gnt, cpu_wait, ram_rd, ram_wr}); end
    host_req = 1'b1;
    #1;
    n_cmp++; if ({host_gnt, cpu_wait} !== 2'b10) begin n_bad++; $display("FAIL rst_host_comb: got %b want 10", {host_gnt, cpu_wait}); end
    host_req = 1'b0;
    tick();
    resetq = 1'b1;
  endtask

  task automatic test_host_read();
    // Preload 0x0100 = A5 through the CPU port.
    tick(); cpu_wr = 1'b1; cpu_a = 16'h0100; cpu_d = 8'hA5; #1;
    n_cmp++; if ({ram_wr, ram_a, ram_d} !== {1'b1, 16'h0100, 8'hA5}) begin n_bad++; $display("FAIL pre_wr: got %b %h %h want 1 0100 a5", ram_wr, ram_a, ram_d); end
    tick(); idle_inputs(); host_req = 1'b1; host_a = 16'h0100; #1;
    n_cmp++; if ({host_gnt, ram_rd, ram_wr, ram_a} !== {3'b110, 16'h0100}) begin n_bad++; $display("FAIL hr_gnt: got %b%b%b %h want 110 0100", host_gnt, ram_rd, ram_wr, ram_a); end
    tick(); idle_inputs(); #1;
    n_cmp++; if ({host_gnt, host_rvalid} !== 2'b00) begin n_bad++; $display("FAIL hr_t1: got %b want 00", {host_gnt, host_rvalid}); end
    tick(); #1;
    n_cmp++; if ({host_rvalid, host_q} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL hr_t2: got %b %h want 1 a5", host_rvalid, host_q); end
    tick(); #1;
    n_cmp++; if ({host_rvalid, host_q} !== {1'b0, 8'hA5}) begin n_bad++; $display("FAIL hr_t3: got %b %h want 0 a5", host_rvalid, host_q); end
  endtask

  task automatic test_cpu_priority();
    tick();
    cpu_wr = 1'b1; cpu_a = 16'h0200; cpu_d = 8'h3C;
    host_req = 1'b1; host_we = 1'b1; host_a = 16'h0300; host_d = 8'h5A;
    #1;
    n_cmp++; if ({host_gnt, cpu_wait} !== 2'b00) begin n_bad++; $display("FAIL pri_gnt: got %b want 00", {host_gnt, cpu_wait}); end
    n_cmp++; if ({ram_wr, ram_rd, ram_a, ram_d} !== {2'b10, 16'h0200, 8'h3C}) begin n_bad++; $display("FAIL pri_bus: got %b%b %h %h want 10 0200 3c", ram_wr, ram_rd, ram_a, ram_d); end
    tick(); cpu_wr = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00; #1;
    n_cmp++; if ({host_gnt, ram_wr, ram_rd, ram_a, ram_d} !== {3'b110, 16'h0300, 8'h5A}) begin n_bad++; $display("FAIL pri_host: got %b%b%b %h %h want 110 0300 5a", host_gnt, ram_wr, ram_rd, ram_a, ram_d); end
    tick(); idle_inputs(); cpu_rd = 1'b1; cpu_a = 16'h0200; #1;
    n_cmp++; if ({ram_rd, ram_wr} !== 2'b10) begin n_bad++; $display("FAIL pri_rb_strobe: got %b want 10", {ram_rd, ram_wr}); end
    tick(); idle_inputs(); #1;
    n_cmp++; if (cpu_q !== 8'h3C) begin n_bad++; $display("FAIL pri_rb_cpu: got %h want 3c", cpu_q); end
  endtask

  task automatic test_back_to_back();
    tick(); host_req = 1'b1; host_a = 16'h0300; #1;
    n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_g0: got %b want 1", host_gnt); end
    tick(); host_a = 16'h0200; #1;
    n_cmp++; if ({host_gnt, host_rvalid} !== 2'b10) begin n_bad++; $display("FAIL b2b_g1: got %b want 10", {host_gnt, host_rvalid}); end
    tick(); host_a = 16'h0100; #1;
    n_cmp++; if ({host_rvalid, host_q} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL b2b_q0: got %b %h want 1 5a", host_rvalid, host_q); end
    tick(); idle_inputs(); #1;
    n_cmp++; if ({host_rvalid, host_q} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL b2b_q1: got %b %h want 1 3c", host_rvalid, host_q); end
    tick(); #1;
    n_cmp++; if ({host_rvalid, host_q} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL b2b_q2: got %b %h want 1 a5", host_rvalid, host_q); end
    tick(); #1;
    n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b want 0", host_rvalid); end
  endtask

  task automatic test_both_strobes();
    tick(); cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_a = 16'h0010; cpu_d = 8'h77; #1;
    n_cmp++; if ({ram_wr, ram_rd, ram_a} !== {2'b10, 16'h0010}) begin n_bad++; $display("FAIL rw_strobe: got %b%b %h want 10 0010", ram_wr, ram_rd, ram_a); end
    tick(); idle_inputs(); cpu_rd = 1'b1; cpu_a = 16'h0010; #1;
    tick(); idle_inputs(); #1;
    n_cmp++; if (cpu_q !== 8'h77) begin n_bad++; $display("FAIL rw_readback: got %h want 77", cpu_q); end
  endtask

`ifdef RAM_ARBITER_STARVE_EN
  task automatic test_starve();
    for (int c = 0; c <= 10; c++) begin
      tick();
      cpu_rd = 1'b1; cpu_a = 16'h0010;
      host_req = (c <= 9); host_we = 1'b0; host_a = 16'h0100;
      #1;
      n_cmp++; if ({host_gnt, cpu_wait} !== {2{c == 9}}) begin n_bad++; $display("FAIL starve_c%0d: got %b want %b", c, {host_gnt, cpu_wait}, {2{c == 9}}); end
      if (c == 9) begin
        n_cmp++; if ({ram_rd, ram_a} !== {1'b1, 16'h0100}) begin n_bad++; $display("FAIL starve_bus: got %b %h want 1 0100", ram_rd, ram_a); end
      end
      if (c == 10) begin
        n_cmp++; if ({ram_rd, ram_a} !== {1'b1, 16'h0010}) begin n_bad++; $display("FAIL starve_retry: got %b %h want 1 0010", ram_rd, ram_a); end
      end
    end
    tick(); idle_inputs(); #1;
    n_cmp++; if ({host_rvalid, host_q, cpu_q} !== {1'b1, 8'hA5, 8'h77}) begin n_bad++; $display("FAIL starve_data: got %b %h %h want 1 a5 77", host_rvalid, host_q, cpu_q); end
  endtask
`else
  task automatic test_starve();
    for (int c = 0; c < 100; c++) begin
      tick();
      cpu_rd = 1'b1; cpu_a = 16'h0010;
      host_req = 1'b1; host_we = 1'b0; host_a = 16'h0100;
      #1;
      n_cmp++; if ({host_gnt, cpu_wait} !== 2'b00) begin n_bad++; $display("FAIL starve_c%0d: got %b want 00", c, {host_gnt, cpu_wait}); end
    end
    tick(); cpu_rd = 1'b0; #1;
    n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL starve_idle_gnt: got %b want 1", host_gnt); end
    tick(); idle_inputs(); #1;
    tick(); #1;
    n_cmp++; if ({host_rvalid, host_q} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL starve_data: got %b %h want 1 a5", host_rvalid, host_q); end
  endtask
`endif

  task automatic test_reset_mid_read();
    tick(); host_req = 1'b1; host_a = 16'h0200; #1;
    n_cmp++; if (host_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_gnt: got %b want 1", host_gnt); end
    tick(); idle_inputs(); resetq = 1'b0; #1;
    n_cmp++; if ({host_rvalid, host_q} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL mid_rst: got %b %h want 0 00", host_rvalid, host_q); end
    #2 resetq = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      n_cmp++; if ({host_rvalid, host_q} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL mid_after_c%0d: got %b %h want 0 00", c, host_rvalid, host_q); end
    end
  endtask

  initial begin
    test_reset();
    test_host_read();
    test_cpu_priority();
    test_back_to_back();
    test_both_strobes();
    test_starve();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single synchronous system RAM between the cdp1802 core and a host/loader port (debug monitor, DMA-style image loader). It sits between the CPU's `ram_*` bus and the `ram` instance in the top level. It multiplexes address, data and strobes onto the RAM and routes read data back to the right requester. The CPU has priority by default; an optional starvation guard bounds host latency by stalling the CPU.

## Interface
Parameters:
- `STARVE_LIMIT`, 8: host-wait cycles before a forced host slot (1..15).

Ports:
- `clock` in 1: system clock, all logic on rising edge.
- `resetq` in 1: asynchronous, active-low reset.
- `cpu_rd` / `cpu_wr` in 1: CPU read/write strobe, single-cycle.
- `cpu_a` in 16 / `cpu_d` in 8: CPU address, write data.
- `cpu_q` out 8: read data to CPU (= `ram_q`, combinational).
- `cpu_wait` out 1: CPU access not performed this cycle; CPU must hold its request.
- `host_req` in 1 / `host_we` in 1: host request, 1 = write.
- `host_a` in 16 / `host_d` in 8: host address, write data.
- `host_gnt` out 1: host access issued to RAM this cycle.
- `host_rvalid` out 1: `host_q` holds data of a granted host read.
- `host_q` out 8: registered host read data.
- `ram_rd` / `ram_wr` out 1: RAM strobes.
- `ram_a` out 16 / `ram_d` out 8: RAM address, write data.
- `ram_q` in 8: RAM read data, valid the cycle after `ram_rd`.

## Operation
- `cpu_act` = `cpu_rd | cpu_wr`. If both strobes are high, the access is a write: `ram_wr=1`, `ram_rd=0`.
- Grant decision is combinational per cycle, from the requests and the starvation flag `force`:
  - Host granted if `host_req & (!cpu_act | force)`.
  - Otherwise the CPU is granted if `cpu_act`.
  - Otherwise no access: `ram_rd = ram_wr = 0`, `ram_a = cpu_a`, `ram_d = cpu_d`.
- Host grant drives `ram_a = host_a`, `ram_d = host_d`, `ram_wr = host_we`, `ram_rd = !host_we`, and `host_gnt = 1`.
- `cpu_wait = cpu_act & host_gnt`.
- Host read pipeline, two registered flags:
  - `rd1` is set in the cycle after a host read grant.
  - In the `rd1` cycle, `ram_q` is captured into `host_q`, and `host_rvalid` is pulsed high the following cycle for exactly one cycle.
- `host_q` holds its last value until the next host read completes.
- Back-to-back host reads are legal; the pipeline yields one `host_rvalid` per grant, in order.
- Host holds `host_req` / `host_a` / `host_d` / `host_we` stable until it sees `host_gnt`. One grant = one access; the host drops or updates the request in the next cycle.

## Timing
- Reset (`resetq` low, asynchronous): `host_rvalid=0`, `host_q=8'h00`, `rd1=0`, starvation counter 0, `force=0`.
  - Combinational outputs follow from this: `host_gnt=0` and `cpu_wait=0` unless `host_req & !cpu_act`.
- Reset mid-read drops the in-flight `host_rvalid`; no late pulse after release.
- Host read latency: grant in cycle T → `host_rvalid` high in cycle T+2.
- Host write completes at the rising edge ending cycle T.
- CPU latency is unchanged from the direct connection: 0 added cycles when granted.
- `cpu_q` is meaningful only in the cycle after an un-waited CPU read.

## Configuration
- `RAM_ARBITER_STARVE_EN` defined:
  - A 4-bit counter increments each cycle `host_req & !host_gnt`, and clears on `host_gnt` or when `!host_req`.
  - `force` is registered, set when the counter reaches `STARVE_LIMIT`; cleared by the host grant it causes.
  - The host waits at most `STARVE_LIMIT`+1 cycles under continuous CPU traffic.
- Not defined: `force` is tied 0, the counter is absent, and `cpu_wait` is constant 0. The host is served only in CPU-idle cycles and may starve.

## Structure
- `ram_arb_pkg`: address width (16), data width (8), grant enum {`GNT_NONE`, `GNT_CPU`, `GNT_HOST`}, counter width (4).
- One sub-module `ram_arb_starve`: counter plus `force` register. Instantiated only under `RAM_ARBITER_STARVE_EN`.

## Test plan
- Idle CPU, host read of `16'h0100` preloaded `8'hA5` → `host_gnt` in T, `host_rvalid=1` with `host_q=8'hA5` in T+2 only.
- CPU write `8'h3C` to `16'h0200` in the same cycle as a host write → CPU wins, `host_gnt=0`, `cpu_wait=0`; host granted the first idle cycle; both writes visible on readback.
- `cpu_rd` and `cpu_wr` both high at `16'h0010` → only `ram_wr=1`, RAM location updated.
- With `RAM_ARBITER_STARVE_EN`, `STARVE_LIMIT=8`, CPU accessing every cycle, host holding a request → host granted exactly 9 cycles after the request rises; `cpu_wait=1` in that cycle only; CPU request retried and completed the next cycle.
- Without the macro, same stimulus → `host_gnt` stays 0 for 100 cycles and `cpu_wait` never asserts.
- `resetq` pulsed low in the cycle after a host read grant → `host_rvalid` never pulses, `host_q=8'h00` after reset.
